if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
Decoupling stage between the instruction fetch unit and the decode stage of the pipelined core.
- Accepts {PC, instruction} pairs from fetch over a valid/ready handshake.
- Holds them in a small in-order ring buffer and presents the oldest entry to decode, together with the pre-extracted RISC-V fields, PC+4 and an illegal-encoding flag.
- Supports a single-cycle flush for branch/jump redirects and keeps a saturating count of decode back-pressure cycles.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 2, number of buffer entries; power of two, at least 2
STALL_CNT_W, 16, width of the back-pressure cycle counter

Ports:
clock  input  1  pipeline clock, all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents a valid PC/instruction pair
in_pc  input  XLEN  PC of the fetched instruction
in_instr  input  XLEN  fetched instruction word
in_ready  output  1  buffer can accept a pair this cycle
flush  input  1  redirect: discard all buffered and incoming entries
out_valid  output  1  head entry valid toward decode
out_ready  input  1  decode consumes the head entry this cycle
out_pc  output  XLEN  head entry PC
out_pc_plus4  output  XLEN  head entry PC + 4, modulo 2^XLEN
out_instr  output  XLEN  head entry instruction
out_opcode  output  7  out_instr[6:0]
out_rd  output  5  out_instr[11:7]
out_funct3  output  3  out_instr[14:12]
out_rs1  output  5  out_instr[19:15]
out_rs2  output  5  out_instr[24:20]
out_funct7  output  7  out_instr[31:25]
out_illegal  output  1  out_instr[1:0] != 2'b11 (not a 32-bit encoding)
stall_cycles  output  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- State: write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count (0..DEPTH), entry storage, and the stall counter.
- Reset, sampled synchronously:
  - count, pointers and stall_cycles are cleared to 0.
  - While reset=1: out_valid=0 and in_ready=0.
  - Entry data is not reset. With out_valid=0, all out_* data ports are don't-care.
- Handshake outputs:
  - in_ready = !reset && !flush && (count != DEPTH).
  - out_valid = !reset && !flush && (count != 0).
  - Neither depends on out_ready or in_valid, so there is no combinational path from input to ready.
- Push occurs when in_valid && in_ready: data is written at the write pointer, which then advances.
- Pop occurs when out_valid && out_ready: the read pointer advances.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged. This is legal at any count 1..DEPTH-1.
- Ordering: strictly FIFO. An entry written in cycle N is visible on out_* from cycle N+1 at the earliest (1-cycle latency). There is no bypass.
- Full (count=DEPTH): in_ready=0. Fetch holds its data, and the buffer does not sample in_instr.
- Empty (count=0): out_valid=0.
- Flush:
  - In the flush cycle, in_ready=0 and out_valid=0, so no push or pop occurs.
  - Next cycle: count=0 and both pointers are 0.
  - Flush during reset has no additional effect.
  - Flush with count=0 is harmless.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. After any number of push/pop cycles, ordering stays correct.
- Field outputs and out_illegal are combinational slices of the head entry's stored instruction.
- out_pc_plus4: head PC + 4, truncated to XLEN. 0xFFFFFFFC yields 0x00000000.
- stall_cycles: increments in every cycle where out_valid=1 and out_ready=0, saturates at all-ones, and is cleared only by reset (not by flush).

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and INSTR_W constants.
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM.
  - Field-position localparams.
  - A packed struct fetch_pkt_t {pc, instr}, used as the entry storage type.
- One natural sub-module: rv_predecode. It is purely combinational (instr → opcode/rd/funct3/rs1/rs2/funct7/illegal) and will be reused by decode.

Test Plan:
- Reset then stream: push PC 0x0/0x4/0x8 with instrs 0x00500093, 0x00A00113, 0x002081B3, out_ready=1 → each appears one cycle later in order. For 0x002081B3: opcode 0x33, rd 3, rs1 1, rs2 2, out_pc_plus4 = PC+4.
- Fill: out_ready=0, push 3 entries → after 2 pushes in_ready=0. The third pair is held, not lost. stall_cycles counts 1 per cycle while out_valid=1.
- Simultaneous push+pop at count=1 for 10 cycles → count stays 1, throughput is 1 per cycle, and pointers wrap without reordering.
- Flush with count=2 and in_valid=1 → in the flush cycle out_valid=0 and in_ready=0. Next cycle count=0, and the incoming pair is dropped.
- Boundary: in_pc=0xFFFFFFFC → out_pc_plus4=0x00000000. in_instr=0x00000000 → out_illegal=1. Stall counter forced past 0xFFFF stays at 0xFFFF.
- Reset mid-operation with count=2 → next cycle out_valid=0, stall_cycles=0. First push after reset is output first.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word widths, base opcodes, instruction
// field positions and the fetch packet carried from fetch into decode.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int F3_LSB     = 12;
    localparam int F3_W       = 3;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int REG_W      = 5;
    localparam int F7_LSB     = 25;
    localparam int F7_W       = 7;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    // Compressed encodings have something other than 2'b11 in the low bits.
    function automatic logic is_rv32(input logic [INSTR_W-1:0] instr);
        return instr[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/rv_predecode.sv
// Combinational field extraction for a 32-bit RISC-V instruction word;
// shared between the IF/ID buffer and the decode stage.
module rv_predecode
    import riscv_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [F3_W-1:0]     funct3,
    output logic [REG_W-1:0]    rs1,
    output logic [REG_W-1:0]    rs2,
    output logic [F7_W-1:0]     funct7,
    output logic                illegal
);

    assign opcode  = instr[OPCODE_LSB +: OPCODE_W];
    assign rd      = instr[RD_LSB     +: REG_W];
    assign funct3  = instr[F3_LSB     +: F3_W];
    assign rs1     = instr[RS1_LSB    +: REG_W];
    assign rs2     = instr[RS2_LSB    +: REG_W];
    assign funct7  = instr[F7_LSB     +: F7_W];
    assign illegal = !is_rv32(instr);

endmodule

// File: rtl/if_id_buffer.sv
// In-order ring buffer between fetch and decode, presenting the oldest entry
// with pre-extracted fields, PC+4 and a back-pressure cycle counter.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_plus4,
    output logic [XLEN-1:0]        out_instr,
    output logic [6:0]             out_opcode,
    output logic [4:0]             out_rd,
    output logic [2:0]             out_funct3,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [6:0]             out_funct7,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    fetch_pkt_t       mem [DEPTH];
    fetch_pkt_t       head;
    fetch_pkt_t       wr_pkt;
    logic             push, pop;

    // Ready/valid depend only on registered state, reset and flush.
    assign in_ready  = !reset && !flush && (count != CNT_W'(DEPTH));
    assign out_valid = !reset && !flush && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign wr_pkt.pc    = in_pc;
    assign wr_pkt.instr = in_instr;

    // Payload storage carries no reset; validity lives in count alone.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_pkt;
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && !(&stall_cycles))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end

    assign head         = mem[rd_ptr];
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_pc_plus4 = head.pc + XLEN'(4);

    rv_predecode u_predecode (
        .instr   (head.instr),
        .opcode  (out_opcode),
        .rd      (out_rd),
        .funct3  (out_funct3),
        .rs1     (out_rs1),
        .rs2     (out_rs2),
        .funct7  (out_funct7),
        .illegal (out_illegal)
    );

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a queue-based FIFO model predicts
// acceptance and output order; a monitor compares every presented entry.
module tb_if_id_buffer;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_pc, in_instr, out_pc, out_pc_plus4, out_instr;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [15:0] stall_cycles;

    if_id_buffer #(.XLEN(32), .DEPTH(DEPTH), .STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_illegal(out_illegal), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } pkt_t;
    pkt_t exp_q[$];

    int  tests = 0;
    int  fails = 0;
    int  model_seq = 0;
    bit  exp_in_ready, exp_out_valid, cur_ordy, cur_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is simply the number of queued packets.
    task automatic model();
        int occ;
        pkt_t p;
        occ           = exp_q.size();
        exp_in_ready  = !reset && !flush && (occ < DEPTH);
        exp_out_valid = !reset && !flush && (occ > 0);
        cur_ordy      = out_ready;
        cur_rst       = reset;
        if (reset || flush) begin
            exp_q.delete();
        end else if (in_valid && exp_in_ready) begin
            p.pc = in_pc;
            p.instr = in_instr;
            exp_q.push_back(p);
        end
        model_seq++;
    endtask

    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit ordy, input bit fl, input bit rst);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clock);
        #1;
        model();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares handshakes and stall count each cycle, and the head
    // entry's fields whenever an entry is presented.
    int          mon_seq = 0;
    logic [15:0] exp_stall = 16'h0;
    always @(negedge clock) begin
        pkt_t h;
        #2;
        if (mon_seq != model_seq) begin
            mon_seq = model_seq;
            chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_out_valid));
            chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
            if (exp_out_valid && exp_q.size() > 0) begin
                h = exp_q[0];
                chk("out_pc", out_pc, h.pc);
                chk("out_instr", out_instr, h.instr);
                chk("out_pc_plus4", out_pc_plus4, h.pc + 32'd4);
                chk("out_opcode", 32'(out_opcode), h.instr & 32'h7F);
                chk("out_rd", 32'(out_rd), (h.instr >> 7) & 32'h1F);
                chk("out_funct3", 32'(out_funct3), (h.instr >> 12) & 32'h7);
                chk("out_rs1", 32'(out_rs1), (h.instr >> 15) & 32'h1F);
                chk("out_rs2", 32'(out_rs2), (h.instr >> 20) & 32'h1F);
                chk("out_funct7", 32'(out_funct7), h.instr >> 25);
                chk("out_illegal", 32'(out_illegal), 32'((h.instr & 32'h3) != 32'h3));
                if (cur_ordy) void'(exp_q.pop_front());
            end
            if (cur_rst)
                exp_stall = 16'h0;
            else if (exp_out_valid && !cur_ordy && exp_stall != 16'hFFFF)
                exp_stall = exp_stall + 16'd1;
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;
        @(posedge clock);
        #1;
        step(1, 32'h10, 32'h00500093, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // In-order stream with decode always ready.
        step(1, 32'h0, 32'h00500093, 1, 0, 0);
        step(1, 32'h4, 32'h00A00113, 1, 0, 0);
        step(1, 32'h8, 32'h002081B3, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);

        // Fill under back-pressure; the third pair is held until space frees.
        step(1, 32'h100, 32'h00108093, 0, 0, 0);
        step(1, 32'h104, 32'h00210113, 0, 0, 0);
        repeat (4) step(1, 32'h108, 32'h00318193, 0, 0, 0);
        step(1, 32'h108, 32'h00318193, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);

        // Steady push+pop at occupancy 1; pointers wrap repeatedly.
        step(1, 32'h200, 32'h40000033, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(1, 32'h204 + 32'(4 * i), $urandom, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);

        // Flush with two entries held and a pair offered.
        step(1, 32'h300, 32'h00000013, 0, 0, 0);
        step(1, 32'h304, 32'h00000113, 0, 0, 0);
        step(1, 32'h308, 32'h00000213, 1, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);

        // PC wrap and a non-32-bit encoding.
        step(1, 32'hFFFFFFFC, 32'h00000000, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);

        // Drive the stall counter past its maximum.
        step(1, 32'h400, 32'h00100073, 0, 0, 0);
        repeat (65540) step(0, 0, 0, 0, 0, 0);

        // Reset with two entries held, then a fresh push goes out first.
        step(1, 32'h500, 32'h00000533, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h600, 32'h006005B3, 1, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step(bit'($urandom_range(0, 3) != 0), $urandom & 32'hFFFFFFFC, ins,
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 29) == 0), 1'b0);
        end
        repeat (4) step(0, 0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
